serial_addsub: RTL and testbench

Bit-serial two's-complement adder/subtractor with a parameterised operand width and a start/busy/done handshake. It loads both operands in parallel and processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It then presents a parallel result with carry-out and signed-overflow flags. It is the general-purpose replacement for the fixed 4-bit serial adder, for datapaths where area matters more than latency.

---
 rtl/serial_addsub_pkg.sv | 15 +
 rtl/serial_fa_cell.sv | 13 +
 rtl/serial_addsub.sv | 97 +++++++++
 tb/tb_serial_addsub.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and limits for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit full adder used by the serial datapath; purely combinational.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/sub, LSB first, one bit per clock.
// Result, carry-out and signed overflow are presented WIDTH cycles after start.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_addsub: WIDTH out of range 2..32");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // The result LSB falls off the shifter on the final bit, so only the upper bits are stored.
    logic [WIDTH-2:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             s;
    logic             c;
    logic [WIDTH-1:0] res_nxt;

    serial_fa_cell u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .s   (s),
        .c   (c)
    );

    assign res_nxt = {s, res_sh};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= (sub == MODE_SUB) ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_nxt[WIDTH-1:1];
                    carry  <= c;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= res_nxt;
                        cout  <= c;
                        // carry here is still the carry into the MSB
                        ovf   <= carry ^ c;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=8 and WIDTH=4 with hand-computed results.
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, start8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       rst4, start4, sub4, busy4, done4, cout4, ovf4;
    logic [3:0] a4, b4, sum4;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    // Observation mux so one set of tasks serves both instances.
    logic        use4 = 1'b0;
    logic        o_busy, o_done, o_cout, o_ovf;
    logic [31:0] o_sum;
    assign o_busy = use4 ? busy4 : busy8;
    assign o_done = use4 ? done4 : done8;
    assign o_cout = use4 ? cout4 : cout8;
    assign o_ovf  = use4 ? ovf4  : ovf8;
    assign o_sum  = use4 ? {28'd0, sum4} : {24'd0, sum8};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: presents a start, returns at the negedge after the accepting edge.
    task automatic launch(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s);
        if (use4) begin
            a4 = a[3:0]; b4 = b[3:0]; sub4 = s; start4 = 1'b1;
        end else begin
            a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
        end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
        check({tag, "_nodone"}, {31'd0, o_done}, 32'd0);
    endtask

    // cyc0 = edges already elapsed since the accepting edge.
    task automatic finish(input string tag, input int cyc0, input int w,
                          input logic [7:0] es, input logic ec, input logic eo);
        int cyc;
        cyc = cyc0;
        while (!o_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, cyc, w);
        check({tag, "_sum"}, o_sum, {24'd0, es});
        check({tag, "_cout"}, {31'd0, o_cout}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, o_ovf}, {31'd0, eo});
        check({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        rst8 = 1'b1; rst4 = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        rst8 = 1'b0; rst4 = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_sum",  {24'd0, sum8}, 32'd0);
        check("rst_flags", {30'd0, cout8, ovf8}, 32'd0);

        launch("add5a3c", 8'h5A, 8'h3C, 1'b0);
        finish("add5a3c", 0, 8, 8'h96, 1'b0, 1'b1);
        @(negedge clk);
        check("done_pulse", {31'd0, done8}, 32'd0);
        check("sum_hold", {24'd0, sum8}, 32'h96);

        launch("sub1020", 8'h10, 8'h20, 1'b1);
        finish("sub1020", 0, 8, 8'hF0, 1'b0, 1'b0);
        @(negedge clk);
        launch("sub8001", 8'h80, 8'h01, 1'b1);
        finish("sub8001", 0, 8, 8'h7F, 1'b1, 1'b1);
        @(negedge clk);

        launch("addff01", 8'hFF, 8'h01, 1'b0);
        finish("addff01", 0, 8, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        launch("add0102", 8'h01, 8'h02, 1'b0);
        repeat (4) @(negedge clk);
        check("sum_stable_mid", {24'd0, sum8}, 32'h00);
        check("cout_stable_mid", {31'd0, cout8}, 32'd1);
        finish("add0102", 4, 8, 8'h03, 1'b0, 1'b0);
        @(negedge clk);

        // Re-pulse start with other operands while busy; must be ignored.
        launch("ign", 8'h12, 8'h34, 1'b0);
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        finish("ign", 3, 8, 8'h46, 1'b0, 1'b0);
        @(negedge clk);

        // Asynchronous abort mid-operation.
        launch("abort", 8'h5A, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        check("abort_done", {31'd0, done8}, 32'd0);
        check("abort_sum",  {24'd0, sum8}, 32'd0);
        check("abort_flags", {30'd0, cout8, ovf8}, 32'd0);
        @(negedge clk);
        rst8 = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_nodone", {31'd0, done8}, 32'd0);
        launch("post_rst", 8'h80, 8'h01, 1'b1);
        finish("post_rst", 0, 8, 8'h7F, 1'b1, 1'b1);
        @(negedge clk);

        // WIDTH=4 instance with back-to-back start in the done cycle.
        use4 = 1'b1;
        launch("w4_add71", 8'h07, 8'h01, 1'b0);
        finish("w4_add71", 0, 4, 8'h08, 1'b0, 1'b1);
        launch("w4_b2b", 8'h03, 8'h02, 1'b0);
        finish("w4_b2b", 0, 4, 8'h05, 1'b0, 1'b0);
        launch("w4_sub35", 8'h03, 8'h05, 1'b1);
        finish("w4_sub35", 0, 4, 8'h0E, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
